// File: rtl/e203_csr_acc_arb.sv
// e203_csr_acc_arb: shares the single CSR file port between the EXU CSR
// instruction path and the debug-module abstract-command path. Each granted
// request becomes a read phase, an optional write phase (write/set/clear
// merged here), and a held response carrying the old value and illegal flag.
module e203_csr_acc_arb #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_mode,

  input  logic        exu_req_valid,
  output logic        exu_req_ready,
  input  logic [1:0]  exu_req_op,
  input  logic [11:0] exu_req_idx,
  input  logic [31:0] exu_req_wdat,
  output logic        exu_rsp_valid,
  input  logic        exu_rsp_ready,
  output logic [31:0] exu_rsp_rdat,
  output logic        exu_rsp_ilgl,

  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic [1:0]  dbg_req_op,
  input  logic [11:0] dbg_req_idx,
  input  logic [31:0] dbg_req_wdat,
  output logic        dbg_rsp_valid,
  input  logic        dbg_rsp_ready,
  output logic [31:0] dbg_rsp_rdat,
  output logic        dbg_rsp_ilgl,

  output logic        csr_ena,
  output logic        csr_rd_en,
  output logic        csr_wr_en,
  output logic [11:0] csr_idx,
  output logic [31:0] wbck_csr_dat,
  input  logic [31:0] read_csr_dat,
  input  logic        csr_access_ilgl
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  localparam int            CW  = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          owner_dbg;
  logic [1:0]    op_q;
  logic [11:0]   idx_q;
  logic [31:0]   wdat_q;
  logic [31:0]   old_q;
  logic          ilgl_q;

  logic          prio_valid;
  logic          other_valid;
  logic          grant_other;
  logic          grant_any;
  logic          grant_dbg;
  logic [1:0]    req_op;
  logic [11:0]   req_idx;
  logic [31:0]   req_wdat;
  logic          no_write;
  logic          owner_rsp_ready;

  // Grant decision: priority side wins unless the waiting side is owed a turn.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    prio_valid  = dbg_mode ? dbg_req_valid : exu_req_valid;
    other_valid = dbg_mode ? exu_req_valid : dbg_req_valid;
    grant_other = other_valid && (!prio_valid || (starve_cnt == LIM));
    grant_any   = (state == IDLE) && !rst && (prio_valid || other_valid);
    // Priority side is dbg when dbg_mode=1, so the non-priority grant flips it.
    grant_dbg   = dbg_mode ^ grant_other;
    req_op      = grant_dbg ? dbg_req_op   : exu_req_op;
    req_idx     = grant_dbg ? dbg_req_idx  : exu_req_idx;
    req_wdat    = grant_dbg ? dbg_req_wdat : exu_req_wdat;
  end

  // Decide after the read phase whether a write strobe is needed at all.
  always_comb begin
    no_write        = csr_access_ilgl || (op_q == OP_READ) ||
                      (op_q[1] && (wdat_q == 32'h0));
    owner_rsp_ready = owner_dbg ? dbg_rsp_ready : exu_rsp_ready;
  end

  // Transaction sequencer and starvation counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_dbg  <= 1'b0;
      op_q       <= '0;
      idx_q      <= '0;
      wdat_q     <= '0;
      old_q      <= '0;
      ilgl_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_dbg <= grant_dbg;
            op_q      <= req_op;
            idx_q     <= req_idx;
            wdat_q    <= req_wdat;
            if (grant_other || !other_valid) starve_cnt <= '0;
            else                             starve_cnt <= starve_cnt + CW'(1);
            old_q     <= '0;
            // A debug request outside debug mode never reaches the CSR file.
            if (grant_dbg && !dbg_mode) begin
              ilgl_q <= 1'b1;
              state  <= RESP;
            end else begin
              ilgl_q <= 1'b0;
              state  <= READ;
            end
          end
        end
        READ: begin
          old_q  <= read_csr_dat;
          ilgl_q <= csr_access_ilgl;
          state  <= no_write ? RESP : WRITE;
        end
        WRITE: state <= RESP;
        RESP: begin
          if (owner_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port strobes, merged write data, request handshakes and held responses.
  always_comb begin
    exu_req_ready = grant_any && !grant_dbg;
    dbg_req_ready = grant_any &&  grant_dbg;

    csr_ena      = (state == READ) || (state == WRITE);
    csr_rd_en    = (state == READ);
    csr_wr_en    = (state == WRITE);
    csr_idx      = csr_ena ? idx_q : 12'h0;
    wbck_csr_dat = 32'h0;
    if (state == WRITE) begin
      case (op_q)
        OP_WRITE: wbck_csr_dat = wdat_q;
        OP_SET:   wbck_csr_dat = old_q | wdat_q;
        OP_CLR:   wbck_csr_dat = old_q & ~wdat_q;
        default:  wbck_csr_dat = 32'h0;
      endcase
    end

    exu_rsp_valid = (state == RESP) && !owner_dbg;
    dbg_rsp_valid = (state == RESP) &&  owner_dbg;
    exu_rsp_rdat  = exu_rsp_valid ? old_q : 32'h0;
    dbg_rsp_rdat  = dbg_rsp_valid ? old_q : 32'h0;
    exu_rsp_ilgl  = exu_rsp_valid && ilgl_q;
    dbg_rsp_ilgl  = dbg_rsp_valid && ilgl_q;
  end

endmodule
